// File: rtl/input_debouncer.sv
// Per-bit 2-FF synchronizer, counter debounce and sticky edge flags behind a registered read port.
// Define DEBOUNCE_FALL_EDGE_EN to add fall-edge flags readable (and cleared) via rd_sel_i = 2'b10.
module input_debouncer #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    input  logic             rd_en_i,
    input  logic [1:0]       rd_sel_i,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] level_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYC - 1);
    localparam int unsigned      PadW   = 32 - WIDTH;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] sel_data;
    logic             rise_clr;
`ifdef DEBOUNCE_FALL_EDGE_EN
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             fall_clr;
`endif

    // Any sample agreeing with the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        case (rd_sel_i)
            2'b00:   sel_data = stable_q;
            2'b01:   sel_data = rise_q;
`ifdef DEBOUNCE_FALL_EDGE_EN
            2'b10:   sel_data = fall_q;
`endif
            default: sel_data = '0;
        endcase

        rd_valid_d = rd_en_i;
        rd_data_d  = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = {{PadW{1'b0}}, sel_data};
        end

        // New edges are OR-ed in after the clear so an event coinciding with a read survives.
        rise_clr = rd_en_i && (rd_sel_i == 2'b01);
        rise_d   = (rise_clr ? '0 : rise_q) | (stable_d & ~stable_q);
`ifdef DEBOUNCE_FALL_EDGE_EN
        fall_clr = rd_en_i && (rd_sel_i == 2'b10);
        fall_d   = (fall_clr ? '0 : fall_q) | (~stable_d & stable_q);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            rise_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef DEBOUNCE_FALL_EDGE_EN
            fall_q     <= '0;
`endif
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            rise_q     <= rise_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef DEBOUNCE_FALL_EDGE_EN
            fall_q     <= fall_d;
`endif
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign level_o    = stable_q;

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Read-side input port for the LSU: captures asynchronous switch/button inputs and presents stable values on a registered read interface.
- Per bit: 2-FF synchronizer, then counter-based debounce, then sticky edge flags cleared on read.
- Complements the output-side storage elements. Output latches are written by the core; this block is read by the core.

Parameters:
- WIDTH, 16, number of input bits (1..16)
- DEBOUNCE_CYC, 50000, consecutive stable cycles required to accept a new level (>= 2)
- CNT_W, 16, per-bit counter width; must satisfy 2**CNT_W > DEBOUNCE_CYC-1

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- raw_i  input  WIDTH  asynchronous switch/button inputs
- rd_en_i  input  1  read strobe from LSU, one cycle per read
- rd_sel_i  input  2  read select: 00 level, 01 rise flags, 10 fall flags, 11 reserved
- rd_data_o  output  32  read data, zero-extended from WIDTH
- rd_valid_o  output  1  one-cycle pulse marking rd_data_o updated
- level_o  output  WIDTH  debounced level, direct (unregistered view of state)

Behaviour:
- Reset (rst_i high, asynchronous): sync1, sync2, stable state, counters, rise/fall flags, rd_data_o and rd_valid_o all go to 0. level_o reads 0.
- Reset mid-count discards progress. After release, counting restarts from 0.
- Synchronizer: sync1 <= raw_i; sync2 <= sync1. Both are per bit.
- Debounce, per bit i, with states COUNT and IDLE implied by the counter:
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - sync2[i] != stable[i] and cnt[i] < DEBOUNCE_CYC-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != stable[i] and cnt[i] == DEBOUNCE_CYC-1: stable[i] <= sync2[i] and cnt[i] <= 0.
- Latency: a raw change held steadily reaches level_o exactly 2 + DEBOUNCE_CYC clock edges later.
- A glitch shorter than DEBOUNCE_CYC cycles at sync2 produces no level change. A single opposite sample resets the count.
- Rise flag: rise[i] set on the cycle stable[i] goes 0->1. It is sticky until read.
- Read, at rd_en_i at edge N:
  - At edge N+1, rd_data_o is loaded with the selection from rd_sel_i; upper 32-WIDTH bits are 0.
  - rd_valid_o is 1 for exactly the cycle following edge N+1.
  - rd_data_o holds its value between reads.
- Clear-on-read: a read with rd_sel_i=01 clears every rise flag that was 1 at edge N.
- Simultaneous new edge and clear on the same bit: set wins, so the flag stays 1 and the event is not lost. The returned data reflects flags before that edge.
- rd_sel_i=11 (reserved): returns 0 and clears nothing.
- Back-to-back reads on consecutive cycles are all serviced, with one-cycle latency each.
- Reads have no effect on debounce state or counters.

Optional Feature:
- Macro: DEBOUNCE_FALL_EDGE_EN.
- Defined:
  - fall[i] is set on the cycle stable[i] goes 1->0.
  - A read with rd_sel_i=10 returns the fall flags and clears them, with the same set-wins rule as the rise flags.
- Undefined:
  - No fall flag storage exists.
  - rd_sel_i=10 returns 0 and has no side effect.

Test Plan (WIDTH=4, DEBOUNCE_CYC=4):
- Reset check: hold rst_i high, toggle raw_i=4'hF. Then level_o=0, rd_data_o=0, rd_valid_o=0. Release reset, raw_i=0, read sel 00 -> rd_data_o=0.
- Accept level: raw_i goes 4'h0 -> 4'h1 and is held. level_o[0] rises exactly 6 edges later. Read sel 00 -> rd_data_o=32'h1 one cycle after rd_en_i, with rd_valid_o pulsing once.
- Glitch rejection: bit1 pulses high for 3 cycles, then low. level_o[1] stays 0 and the rise flag stays 0.
- Clear-on-read: after bit0 rises, read sel 01 -> 32'h1. An immediate second read sel 01 -> 32'h0.
- Set wins over clear: align bit2's 0->1 stable transition with a sel 01 read edge. That read returns 32'h0 (or the prior flags); the next read returns bit2=1.
- Fall flags: with DEBOUNCE_FALL_EDGE_EN, bit0 goes 1->0 held, then read sel 10 -> 32'h1. Without the macro, the same read -> 32'h0.
